// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
// Status (halt/fault/state) travels with the controls so the datapath can observe them.
interface multicycle_controller_if #(
  parameter int OPCODE_W = 7
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                halt_req;
  logic                ir_write;
  logic                pc_write;
  logic                alu_src;
  logic                mem_to_reg;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic [1:0]          alu_op;
  logic                halt;
  logic                fault;
  logic [2:0]          state;

  modport master (
    input  opcode, mem_ready, halt_req,
    output ir_write, pc_write, alu_src, mem_to_reg, reg_write, mem_read,
           mem_write, branch, alu_op, halt, fault, state
  );

  modport slave (
    output opcode, mem_ready, halt_req,
    input  ir_write, pc_write, alu_src, mem_to_reg, reg_write, mem_read,
           mem_write, branch, alu_op, halt, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: BR 3 cycles, R/I/JAL/JALR/LUI/SW 4, LW 5 at full memory speed.
// Memory stalls hold FETCH/MEM until mem_ready; a bounded wait (TIMEOUT) escalates to FAULT.
module multicycle_controller #(
  parameter int OPCODE_W = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b0000001);

  // A zero TIMEOUT still needs a 1-bit counter; it simply never advances.
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                halt_pend_q, halt_pend_d;
  logic                timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_cnt_q  <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_cnt_q  <= wait_cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wait_cnt_d     = wait_cnt_q;
    halt_pend_d    = halt_pend_q | bus.halt_req;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.branch     = 1'b0;
    bus.alu_op     = 2'b00;
    bus.halt       = 1'b0;
    bus.fault      = 1'b0;
    bus.state      = state_q;
    timeout_hit    = (TIMEOUT > 0) && !bus.mem_ready && (wait_cnt_q == CNT_MAX);

    case (state_q)
      S_FETCH: begin
        // Instruction boundary: a pending stop wins before any memory request.
        if (halt_pend_q || bus.halt_req) begin
          state_d = S_HALT;
        end else begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
          end else if (timeout_hit) begin
            state_d = S_FAULT;
          end
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_HALT: state_d = S_HALT;
          OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI: state_d = S_EXEC;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_SW: begin
            bus.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          OP_I: begin
            bus.alu_src = 1'b1;
            bus.alu_op  = 2'b10;
            state_d     = S_WB;
          end
          OP_R: begin
            bus.alu_op = 2'b10;
            state_d    = S_WB;
          end
          OP_LUI: begin
            bus.alu_src = 1'b1;
            bus.alu_op  = 2'b11;
            state_d     = S_WB;
          end
          OP_JAL, OP_JALR: begin
            bus.branch = 1'b1;
            bus.alu_op = 2'b11;
            state_d    = S_WB;
          end
          OP_BR: begin
            bus.branch = 1'b1;
            bus.alu_op = 2'b01;
            state_d    = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        bus.mem_read  = (op_q == OP_LW);
        bus.mem_write = (op_q != OP_LW);
        if (bus.mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (op_q == OP_LW);
        state_d        = S_FETCH;
      end
      S_HALT: begin
        bus.halt = 1'b1;
      end
      S_FAULT: begin
        bus.halt  = 1'b1;
        bus.fault = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase

    if (state_q == S_FETCH || state_q == S_MEM) begin
      if (bus.mem_ready) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != CNT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
      wait_cnt_d = '0;
    end

    // Reset silences everything so an abandoned store or writeback never escapes.
    if (reset) begin
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.alu_src    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.branch     = 1'b0;
      bus.alu_op     = 2'b00;
      bus.halt       = 1'b0;
      bus.fault      = 1'b0;
      bus.state      = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with TIMEOUT=4.
// Each step drives inputs after a rising edge and checks state plus all controls before the next.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  multicycle_controller_if #(.OPCODE_W(7)) bus ();

  multicycle_controller #(.OPCODE_W(7), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] ctl;
  assign ctl = {bus.ir_write, bus.pc_write, bus.alu_src, bus.mem_to_reg,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.branch,
                bus.alu_op, bus.halt, bus.fault};

  localparam logic [11:0] IRW   = 12'h800;
  localparam logic [11:0] PCW   = 12'h400;
  localparam logic [11:0] ASRC  = 12'h200;
  localparam logic [11:0] M2R   = 12'h100;
  localparam logic [11:0] RW    = 12'h080;
  localparam logic [11:0] MR    = 12'h040;
  localparam logic [11:0] MW    = 12'h020;
  localparam logic [11:0] BRN   = 12'h010;
  localparam logic [11:0] AOP01 = 12'h004;
  localparam logic [11:0] AOP10 = 12'h008;
  localparam logic [11:0] AOP11 = 12'h00C;
  localparam logic [11:0] HLT   = 12'h002;
  localparam logic [11:0] FLT   = 12'h001;
  localparam logic [11:0] FCH   = IRW | PCW | MR;
  localparam logic [11:0] NONE  = 12'h000;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_HALT = 7'b0000001;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  task automatic check(input string tag, input logic [2:0] exp_state, input logic [11:0] exp_ctl);
    n_assert++;
    assert (bus.state === exp_state) else begin
      n_fail++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, bus.state, exp_state);
    end
    n_assert++;
    assert (ctl === exp_ctl) else begin
      n_fail++;
      $error("FAIL %s.ctl observed=%03h expected=%03h", tag, ctl, exp_ctl);
    end
  endtask

  // One cycle: drive inputs, let combinational outputs settle, check, advance.
  task automatic cyc(input string tag, input logic mr, input logic hr, input logic [6:0] op,
                     input logic [2:0] exp_state, input logic [11:0] exp_ctl);
    bus.mem_ready = mr;
    bus.halt_req  = hr;
    bus.opcode    = op;
    #1;
    check(tag, exp_state, exp_ctl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.halt_req  = 1'b0;
    #1;
    check(tag, 3'd0, NONE);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.halt_req  = 1'b0;
    bus.opcode    = '0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Fetch stalls to wait_cnt==TIMEOUT, then mem_ready in that cycle wins; R-type follows.
    cyc("fst1", 0, 0, OP_R, 3'd0, MR);
    cyc("fst2", 0, 0, OP_R, 3'd0, MR);
    cyc("fst3", 0, 0, OP_R, 3'd0, MR);
    cyc("fst4", 0, 0, OP_R, 3'd0, MR);
    cyc("fst5", 1, 0, OP_R, 3'd0, FCH);
    cyc("r_d",  1, 0, OP_R, 3'd1, NONE);
    cyc("r_e",  1, 0, OP_R, 3'd2, AOP10);
    cyc("r_wb", 1, 0, OP_R, 3'd4, RW);

    cyc("br_f", 1, 0, OP_BR, 3'd0, FCH);
    cyc("br_d", 1, 0, OP_BR, 3'd1, NONE);
    cyc("br_e", 1, 0, OP_BR, 3'd2, BRN | AOP01);

    cyc("i_f",  1, 0, OP_I, 3'd0, FCH);
    cyc("i_d",  1, 0, OP_I, 3'd1, NONE);
    cyc("i_e",  1, 0, OP_I, 3'd2, ASRC | AOP10);
    cyc("i_wb", 1, 0, OP_I, 3'd4, RW);

    cyc("jal_f",  1, 0, OP_JAL, 3'd0, FCH);
    cyc("jal_d",  1, 0, OP_JAL, 3'd1, NONE);
    cyc("jal_e",  1, 0, OP_JAL, 3'd2, BRN | AOP11);
    cyc("jal_wb", 1, 0, OP_JAL, 3'd4, RW);

    cyc("lui_f",  1, 0, OP_LUI, 3'd0, FCH);
    cyc("lui_d",  1, 0, OP_LUI, 3'd1, NONE);
    cyc("lui_e",  1, 0, OP_LUI, 3'd2, ASRC | AOP11);
    cyc("lui_wb", 1, 0, OP_LUI, 3'd4, RW);

    // Load with three memory wait cycles.
    cyc("lw_f",  1, 0, OP_LW, 3'd0, FCH);
    cyc("lw_d",  1, 0, OP_LW, 3'd1, NONE);
    cyc("lw_e",  1, 0, OP_LW, 3'd2, ASRC);
    cyc("lw_m1", 0, 0, OP_LW, 3'd3, MR);
    cyc("lw_m2", 0, 0, OP_LW, 3'd3, MR);
    cyc("lw_m3", 0, 0, OP_LW, 3'd3, MR);
    cyc("lw_m4", 1, 0, OP_LW, 3'd3, MR);
    cyc("lw_wb", 1, 0, OP_LW, 3'd4, RW | M2R);

    // Stop request during a store's EXEC: store completes, then HALT without a fetch.
    cyc("swh_f",  1, 0, OP_SW, 3'd0, FCH);
    cyc("swh_d",  1, 0, OP_SW, 3'd1, NONE);
    cyc("swh_e",  1, 1, OP_SW, 3'd2, ASRC);
    cyc("swh_m",  1, 0, OP_SW, 3'd3, MW);
    cyc("swh_f2", 1, 0, OP_SW, 3'd0, NONE);
    cyc("swh_h1", 1, 0, OP_SW, 3'd5, HLT);
    cyc("swh_h2", 1, 1, OP_SW, 3'd5, HLT);
    do_reset("rst1");

    // Reset arriving in a store's MEM state abandons the write.
    cyc("swr_f", 1, 0, OP_SW, 3'd0, FCH);
    cyc("swr_d", 1, 0, OP_SW, 3'd1, NONE);
    cyc("swr_e", 1, 0, OP_SW, 3'd2, ASRC);
    do_reset("swr_m_rst");
    cyc("swr_f2", 1, 0, OP_SW, 3'd0, FCH);

    cyc("bad_d",  1, 0, OP_BAD, 3'd1, NONE);
    cyc("bad_x1", 1, 0, OP_BAD, 3'd6, HLT | FLT);
    cyc("bad_x2", 1, 1, OP_BAD, 3'd6, HLT | FLT);
    do_reset("rst2");

    cyc("hop_f", 1, 0, OP_HALT, 3'd0, FCH);
    cyc("hop_d", 1, 0, OP_HALT, 3'd1, NONE);
    cyc("hop_h", 1, 0, OP_HALT, 3'd5, HLT);
    do_reset("rst3");

    // Fetch never answered: five FETCH cycles, then sticky FAULT.
    cyc("to1", 0, 0, OP_R, 3'd0, MR);
    cyc("to2", 0, 0, OP_R, 3'd0, MR);
    cyc("to3", 0, 0, OP_R, 3'd0, MR);
    cyc("to4", 0, 0, OP_R, 3'd0, MR);
    cyc("to5", 0, 0, OP_R, 3'd0, MR);
    cyc("to_x1", 0, 0, OP_R, 3'd6, HLT | FLT);
    cyc("to_x2", 1, 1, OP_R, 3'd6, HLT | FLT);
    do_reset("rst4");
    cyc("post_f", 1, 0, OP_R, 3'd0, FCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
